// File: rtl/cmp_writeback.sv
// Compare-result writeback queue: buffers up to NUM_CMP_RS results per cycle and drains them in order to the ROB.
// Optional macro CMP_WB_BYPASS_EN forwards the lowest valid input straight to the ROB port when the queue is empty.
module cmp_writeback #(
  parameter int NUM_CMP_RS = 3,
  parameter int DEPTH      = 16,
  parameter int TAG_W      = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [NUM_CMP_RS-1:0]               in_valid,
  input  logic [NUM_CMP_RS-1:0]               in_is_br,
  input  logic [NUM_CMP_RS-1:0]               in_br_pred_res,
  input  logic [NUM_CMP_RS-1:0][31:0]         in_val,
  input  logic [NUM_CMP_RS-1:0][31:0]         in_pc_next,
  input  logic [NUM_CMP_RS-1:0][TAG_W-1:0]    in_tag,
  output logic                                dispatch_stall,
  output logic                                rob_wr_valid,
  input  logic                                rob_wr_ready,
  output logic [TAG_W-1:0]                    rob_wr_tag,
  output logic [31:0]                         rob_wr_val,
  output logic                                rob_wr_mispred,
  output logic [31:0]                         rob_wr_pc_next,
  output logic                                overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (NUM_CMP_RS > 1) ? $clog2(NUM_CMP_RS) : 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_LIM = CW'(2 * NUM_CMP_RS);

  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic [31:0]      mem_val [DEPTH];
  logic [31:0]      mem_pc  [DEPTH];
  logic             mem_mis [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;

  logic          fifo_valid;
  logic          pop;
  logic [CW-1:0] free;
  logic [CW-1:0] n_acc;
  logic          drop;
  logic [NUM_CMP_RS-1:0] wr_en;
  logic [AW-1:0]         wr_idx [NUM_CMP_RS];

  logic          byp_active;
  logic          byp_take;
  logic [SW-1:0] byp_idx;

  assign fifo_valid     = (count != '0) & ~flush & ~rst;
  assign pop            = fifo_valid & rob_wr_ready;
  assign dispatch_stall = ~rst & ((DEPTH_C - count) < STALL_LIM);

`ifdef CMP_WB_BYPASS_EN
  always_comb begin
    byp_idx = '0;
    for (int i = NUM_CMP_RS - 1; i >= 0; i--) begin
      if (in_valid[i]) byp_idx = SW'(i);
    end
  end
  assign byp_active = (count == '0) & (|in_valid) & ~flush & ~rst;
  assign byp_take   = byp_active & rob_wr_ready;
`else
  assign byp_idx    = '0;
  assign byp_active = 1'b0;
  assign byp_take   = 1'b0;
`endif

  // Slots are packed into consecutive tail positions; the entry freed by a same-cycle pop is reusable.
  always_comb begin
    n_acc = '0;
    drop  = 1'b0;
    free  = DEPTH_C - count + CW'(pop);
    for (int i = 0; i < NUM_CMP_RS; i++) begin
      wr_en[i]  = 1'b0;
      wr_idx[i] = tail + AW'(n_acc);
      if (in_valid[i] & ~flush & ~rst & ~(byp_take & (byp_idx == SW'(i)))) begin
        if (n_acc < free) begin
          wr_en[i] = 1'b1;
          n_acc    = n_acc + CW'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) head <= head + AW'(1);
      tail  <= tail + AW'(n_acc);
      count <= count + n_acc - CW'(pop);
      if (drop) overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CMP_RS; i++) begin
      if (wr_en[i]) begin
        mem_tag[wr_idx[i]] <= in_tag[i];
        mem_val[wr_idx[i]] <= in_val[i];
        mem_pc[wr_idx[i]]  <= in_pc_next[i];
        mem_mis[wr_idx[i]] <= in_is_br[i] & ~in_br_pred_res[i];
      end
    end
  end

  // Payload reads as zero whenever nothing is being offered.
  always_comb begin
    rob_wr_valid   = 1'b0;
    rob_wr_tag     = '0;
    rob_wr_val     = '0;
    rob_wr_pc_next = '0;
    rob_wr_mispred = 1'b0;
    if (fifo_valid) begin
      rob_wr_valid   = 1'b1;
      rob_wr_tag     = mem_tag[head];
      rob_wr_val     = mem_val[head];
      rob_wr_pc_next = mem_pc[head];
      rob_wr_mispred = mem_mis[head];
    end else if (byp_active) begin
      rob_wr_valid   = 1'b1;
      rob_wr_tag     = in_tag[byp_idx];
      rob_wr_val     = in_val[byp_idx];
      rob_wr_pc_next = in_pc_next[byp_idx];
      rob_wr_mispred = in_is_br[byp_idx] & ~in_br_pred_res[byp_idx];
    end
  end

endmodule

// File: tb/tb_cmp_writeback.sv
// Self-checking bench for cmp_writeback: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_cmp_writeback;
  localparam int N     = 3;
  localparam int DEPTH = 16;
  localparam int TW    = 4;

  logic clk = 1'b0;
  logic rst, flush;
  logic [N-1:0] in_valid, in_is_br, in_br_pred_res;
  logic [N-1:0][31:0] in_val, in_pc_next;
  logic [N-1:0][TW-1:0] in_tag;
  logic dispatch_stall, rob_wr_valid, rob_wr_ready, rob_wr_mispred, overflow_err;
  logic [TW-1:0] rob_wr_tag;
  logic [31:0] rob_wr_val, rob_wr_pc_next;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [31:0]   val;
    logic [31:0]   pc;
    logic          mis;
  } ent_t;

  ent_t q[$];
  bit   m_ovf;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  cmp_writeback #(.NUM_CMP_RS(N), .DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_is_br(in_is_br), .in_br_pred_res(in_br_pred_res),
    .in_val(in_val), .in_pc_next(in_pc_next), .in_tag(in_tag),
    .dispatch_stall(dispatch_stall),
    .rob_wr_valid(rob_wr_valid), .rob_wr_ready(rob_wr_ready),
    .rob_wr_tag(rob_wr_tag), .rob_wr_val(rob_wr_val),
    .rob_wr_mispred(rob_wr_mispred), .rob_wr_pc_next(rob_wr_pc_next),
    .overflow_err(overflow_err)
  );

  function automatic int low_slot();
    for (int i = 0; i < N; i++) if (in_valid[i]) return i;
    return 0;
  endfunction

  function automatic ent_t slot_ent(int i);
    ent_t e;
    e.tag = in_tag[i];
    e.val = in_val[i];
    e.pc  = in_pc_next[i];
    e.mis = in_is_br[i] & ~in_br_pred_res[i];
    return e;
  endfunction

  function automatic bit byp_on();
`ifdef CMP_WB_BYPASS_EN
    return (q.size() == 0) && (|in_valid) && !rst && !flush;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_valid();
    return !rst && !flush && (q.size() != 0 || byp_on());
  endfunction

  function automatic ent_t exp_head();
    if (q.size() != 0) return q[0];
    return slot_ent(low_slot());
  endfunction

  function automatic bit exp_stall();
    return !rst && ((DEPTH - q.size()) < 2 * N);
  endfunction

  // Advance the reference model by one clock using the inputs currently applied, then step the DUT.
  task automatic tick();
    int skip;
    skip = -1;
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (exp_valid() && rob_wr_ready) begin
        if (q.size() != 0) void'(q.pop_front());
        else skip = low_slot();
      end
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && i != skip) begin
          if (q.size() < DEPTH) q.push_back(slot_ent(i));
          else m_ovf = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = '0; in_is_br = '0; in_br_pred_res = '0;
    in_val = '0; in_pc_next = '0; in_tag = '0;
  endtask

  task automatic drain();
    rob_wr_ready = 1'b1;
    clear_inputs();
    for (int k = 0; k < 40 && q.size() != 0; k++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; rob_wr_ready = 1'b0;
    clear_inputs();
    tick(); tick();
    #2;
    n_checks++;
    if ({rob_wr_valid, dispatch_stall, overflow_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: valid/stall/ovf got %b want 000", {rob_wr_valid, dispatch_stall, overflow_err});
    end
    n_checks++;
    if ({rob_wr_tag, rob_wr_val, rob_wr_pc_next, rob_wr_mispred} !== '0) begin
      n_fail++;
      $display("FAIL reset_payload: got tag=%h val=%h pc=%h mis=%b want all 0", rob_wr_tag, rob_wr_val, rob_wr_pc_next, rob_wr_mispred);
    end
    rst = 1'b0;
    #2;
    n_checks++;
    if (rob_wr_valid !== 1'b0 || dispatch_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: valid=%b stall=%b want 0 0", rob_wr_valid, dispatch_stall);
    end
    tick();
  endtask

  task automatic test_single();
    rob_wr_ready = 1'b1;
    clear_inputs();
    in_valid[1] = 1'b1; in_tag[1] = 4'd5; in_val[1] = 32'h1; in_pc_next[1] = 32'h100;
    #2;
    n_checks++;
    if (rob_wr_valid !== exp_valid()) begin
      n_fail++;
      $display("FAIL single_push_cycle: valid got %b want %b", rob_wr_valid, exp_valid());
    end
    tick();
    clear_inputs();
    #2;
`ifndef CMP_WB_BYPASS_EN
    n_checks++;
    if (rob_wr_valid !== 1'b1 || rob_wr_tag !== 4'd5 || rob_wr_val !== 32'h1 || rob_wr_mispred !== 1'b0) begin
      n_fail++;
      $display("FAIL single_next: valid=%b tag=%0d val=%h mis=%b want 1 5 00000001 0", rob_wr_valid, rob_wr_tag, rob_wr_val, rob_wr_mispred);
    end
`endif
    n_checks++;
    if (rob_wr_valid !== exp_valid()) begin
      n_fail++;
      $display("FAIL single_model_valid: got %b want %b", rob_wr_valid, exp_valid());
    end
    drain();
  endtask

  task automatic test_three();
    rob_wr_ready = 1'b1;
    clear_inputs();
    in_valid = 3'b111;
    for (int i = 0; i < N; i++) begin
      in_tag[i] = TW'(i + 1);
      in_val[i] = 32'hA0 + i;
    end
    tick();
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      #2;
      n_checks++;
      if (rob_wr_valid !== exp_valid() || (exp_valid() && rob_wr_tag !== exp_head().tag)) begin
        n_fail++;
        $display("FAIL three_order[%0d]: valid=%b tag=%0d want valid=%b tag=%0d", k, rob_wr_valid, rob_wr_tag, exp_valid(), exp_head().tag);
      end
`ifndef CMP_WB_BYPASS_EN
      n_checks++;
      if (rob_wr_tag !== TW'(k + 1)) begin
        n_fail++;
        $display("FAIL three_tag[%0d]: got %0d want %0d", k, rob_wr_tag, k + 1);
      end
`endif
      tick();
    end
    drain();
  endtask

  task automatic test_branch();
    rob_wr_ready = 1'b0;
    clear_inputs();
    in_valid = 3'b011;
    in_is_br = 3'b011; in_br_pred_res = 3'b010;
    in_tag[0] = 4'd4; in_pc_next[0] = 32'h6000_0020; in_val[0] = 32'h0;
    in_tag[1] = 4'd6; in_pc_next[1] = 32'h6000_0040; in_val[1] = 32'h1;
    tick();
    clear_inputs();
    rob_wr_ready = 1'b1;
    #2;
    n_checks++;
    if (rob_wr_valid !== 1'b1 || rob_wr_tag !== 4'd4 || rob_wr_mispred !== 1'b1 || rob_wr_pc_next !== 32'h6000_0020) begin
      n_fail++;
      $display("FAIL branch_mispred: valid=%b tag=%0d mis=%b pc=%h want 1 4 1 60000020", rob_wr_valid, rob_wr_tag, rob_wr_mispred, rob_wr_pc_next);
    end
    tick();
    #2;
    n_checks++;
    if (rob_wr_valid !== 1'b1 || rob_wr_tag !== 4'd6 || rob_wr_mispred !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_correct: valid=%b tag=%0d mis=%b want 1 6 0", rob_wr_valid, rob_wr_tag, rob_wr_mispred);
    end
    drain();
  endtask

  task automatic test_overflow();
    int seq;
    seq = 0;
    rob_wr_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      clear_inputs();
      in_valid = (c == 0) ? 3'b011 : 3'b111;
      for (int i = 0; i < N; i++) begin
        if (in_valid[i]) begin
          in_tag[i] = TW'((seq % 15) + 1);
          in_val[i] = seq;
          seq++;
        end
      end
      #2;
      n_checks++;
      if (dispatch_stall !== exp_stall()) begin
        n_fail++;
        $display("FAIL ovf_stall[%0d]: got %b want %b", c, dispatch_stall, exp_stall());
      end
      if (c == 3) begin
        n_checks++;
        if (dispatch_stall !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_stall_at8: got %b want 0", dispatch_stall);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (dispatch_stall !== 1'b1 || overflow_err !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_stall_at11: stall=%b ovf=%b want 1 0", dispatch_stall, overflow_err);
        end
      end
      tick();
    end
    clear_inputs();
    #2;
    n_checks++;
    if (overflow_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b want 1", overflow_err);
    end
    rob_wr_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #2;
      n_checks++;
      if (rob_wr_valid !== 1'b1 || rob_wr_val !== 32'(k) || rob_wr_tag !== TW'((k % 15) + 1)) begin
        n_fail++;
        $display("FAIL ovf_drain[%0d]: valid=%b val=%0d tag=%0d want 1 %0d %0d", k, rob_wr_valid, rob_wr_val, rob_wr_tag, k, (k % 15) + 1);
      end
      tick();
    end
    #2;
    n_checks++;
    if (rob_wr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_dropped: valid got %b want 0 after 16 entries", rob_wr_valid);
    end
  endtask

  task automatic test_flush();
    rob_wr_ready = 1'b0;
    clear_inputs();
    in_valid = 3'b111; in_tag[0] = 4'd1; in_tag[1] = 4'd2; in_tag[2] = 4'd3;
    tick();
    clear_inputs();
    in_valid = 3'b001; in_tag[0] = 4'd8;
    tick();
    clear_inputs();
    flush = 1'b1; rob_wr_ready = 1'b1;
    in_valid = 3'b001; in_tag[0] = 4'd9;
    #2;
    n_checks++;
    if (rob_wr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cycle_valid: got %b want 0", rob_wr_valid);
    end
    tick();
    flush = 1'b0;
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      #2;
      n_checks++;
      if (rob_wr_valid !== 1'b0 || dispatch_stall !== 1'b0 || overflow_err !== m_ovf) begin
        n_fail++;
        $display("FAIL flush_after[%0d]: valid=%b stall=%b ovf=%b want 0 0 %b", k, rob_wr_valid, dispatch_stall, overflow_err, m_ovf);
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    rob_wr_ready = 1'b0;
    clear_inputs();
    in_valid = 3'b111; in_tag[0] = 4'd10; in_tag[1] = 4'd11; in_tag[2] = 4'd12;
    tick();
    clear_inputs();
    rst = 1'b1; rob_wr_ready = 1'b1;
    #2;
    n_checks++;
    if (rob_wr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_valid: got %b want 0", rob_wr_valid);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      n_checks++;
      if (rob_wr_valid !== 1'b0 || overflow_err !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_after[%0d]: valid=%b ovf=%b want 0 0", k, rob_wr_valid, overflow_err);
      end
      tick();
    end
  endtask

`ifdef CMP_WB_BYPASS_EN
  task automatic test_bypass();
    rob_wr_ready = 1'b1;
    clear_inputs();
    in_valid = 3'b001; in_tag[0] = 4'd7; in_val[0] = 32'h77;
    #2;
    n_checks++;
    if (rob_wr_valid !== 1'b1 || rob_wr_tag !== 4'd7) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: valid=%b tag=%0d want 1 7", rob_wr_valid, rob_wr_tag);
    end
    tick();
    clear_inputs();
    #2;
    n_checks++;
    if (rob_wr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_empty: valid got %b want 0", rob_wr_valid);
    end
    rob_wr_ready = 1'b0;
    in_valid = 3'b110; in_tag[1] = 4'd3; in_tag[2] = 4'd4;
    tick();
    clear_inputs();
    rob_wr_ready = 1'b1;
    #2;
    n_checks++;
    if (rob_wr_valid !== 1'b1 || rob_wr_tag !== 4'd3) begin
      n_fail++;
      $display("FAIL bypass_refused: valid=%b tag=%0d want 1 3", rob_wr_valid, rob_wr_tag);
    end
    drain();
  endtask
`endif

  task automatic test_random();
    ent_t e;
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 24) == 0);
      rob_wr_ready = ($urandom_range(0, 9) < 6);
      in_valid = N'($urandom_range(0, 7));
      in_is_br = N'($urandom_range(0, 7));
      in_br_pred_res = N'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) begin
        in_tag[i]     = TW'($urandom_range(1, 15));
        in_val[i]     = $urandom;
        in_pc_next[i] = $urandom;
      end
      #2;
      e = exp_head();
      n_checks++;
      if (rob_wr_valid !== exp_valid() || dispatch_stall !== exp_stall() || overflow_err !== m_ovf) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: valid/stall/ovf got %b%b%b want %b%b%b", c, rob_wr_valid, dispatch_stall, overflow_err, exp_valid(), exp_stall(), m_ovf);
      end
      if (exp_valid()) begin
        n_checks++;
        if ({rob_wr_tag, rob_wr_val, rob_wr_pc_next, rob_wr_mispred} !== e) begin
          n_fail++;
          $display("FAIL rand_payload[%0d]: got %h want %h", c, {rob_wr_tag, rob_wr_val, rob_wr_pc_next, rob_wr_mispred}, e);
        end
      end
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    m_ovf = 1'b0;
    test_reset();
    test_single();
    test_three();
    test_branch();
    test_overflow();
    test_flush();
    test_mid_reset();
`ifdef CMP_WB_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_writeback.md
CMP_WRITEBACK -- requirements
Module: cmp_writeback

Interface
REQ-001 The block SHALL have parameter NUM_CMP_RS, default 3: number of compare result slots driven by the compare RS each cycle.
REQ-002 The block SHALL have parameter DEPTH, default 16, power of two, DEPTH >= 2*NUM_CMP_RS: result FIFO entries.
REQ-003 The block SHALL have parameter TAG_W, default 4: ROB tag width; tag 0 is reserved as "no tag".
REQ-004 The block SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port flush  in  1  pipeline flush; synchronous clear.
REQ-007 The block SHALL have ports in_valid / in_is_br / in_br_pred_res  in  NUM_CMP_RS x 1  per-slot result valid, branch flag, and prediction-correct flag.
REQ-008 The block SHALL have ports in_val / in_pc_next  in  NUM_CMP_RS x 32  per-slot result value and resolved next PC.
REQ-009 The block SHALL have port in_tag  in  NUM_CMP_RS x TAG_W  per-slot destination ROB tag.
REQ-010 The block SHALL have port dispatch_stall  out  1  tells the decoder not to issue compare ops.
REQ-011 The block SHALL have ports rob_wr_valid / rob_wr_ready  out / in  1  ROB write handshake.
REQ-012 The block SHALL have ports rob_wr_tag (TAG_W), rob_wr_val (32), rob_wr_mispred (1), rob_wr_pc_next (32)  out  ROB write payload.
REQ-013 The block SHALL have port overflow_err  out  1  sticky error flag.

Function
REQ-014 The block SHALL enqueue every in_valid slot in the same cycle, in ascending slot order, into a circular FIFO with wrap-around head/tail pointers.
REQ-015 The block SHALL store per entry: tag, val, pc_next, and mispred = in_is_br & ~in_br_pred_res.
REQ-016 The block SHALL present the FIFO head on rob_wr_* with rob_wr_valid = (count != 0), and SHALL pop the head only when rob_wr_valid & rob_wr_ready.
REQ-017 The block SHALL hold rob_wr payload stable while rob_wr_valid=1 and rob_wr_ready=0.
REQ-018 The block SHALL, when push and pop occur in the same cycle, compute count_next = count + pushes - pop, and it SHALL accept pushes into the entry being freed.
REQ-019 The block SHALL assert dispatch_stall combinationally when DEPTH - count < 2*NUM_CMP_RS.
REQ-020 The block SHALL, if pushes exceed free entries (after accounting for a same-cycle pop), accept the lowest-index slots that fit, drop the rest, and set overflow_err, which holds until rst.
REQ-021 The block SHALL give a latency of exactly 1 cycle from an in_valid entering an empty FIFO to rob_wr_valid=1, when CMP_WB_BYPASS_EN is undefined.
REQ-022 The block SHALL not reorder entries; ROB writes occur in enqueue order.
REQ-023 The block SHALL, on flush=1, empty the FIFO next cycle, discard that cycle's inputs, and force rob_wr_valid=0 in the flush cycle; overflow_err SHALL be unaffected by flush.
REQ-024 The block SHALL give flush priority over push, pop and bypass when flush is simultaneous with them.

Reset
REQ-025 The block SHALL, on rst=1, clear the head/tail pointers and count to 0.
REQ-026 The block SHALL, on rst=1, set overflow_err=0, rob_wr_valid=0, dispatch_stall=0, and all rob_wr payload outputs to 0.
REQ-027 The block SHALL, when rst is asserted mid-operation, discard all queued entries with no ROB write.

Configuration
REQ-028 The block SHALL, with macro CMP_WB_BYPASS_EN defined and the FIFO empty, drive the lowest-index valid input slot combinationally onto rob_wr_* in the same cycle.
REQ-029 The block SHALL, with CMP_WB_BYPASS_EN defined and the bypassed result accepted (rob_wr_ready=1), not enqueue that slot; the remaining valid slots SHALL enqueue.
REQ-030 The block SHALL, with CMP_WB_BYPASS_EN defined and the bypassed result not accepted, enqueue that slot normally.
REQ-031 The block SHALL, without CMP_WB_BYPASS_EN, contain no input-to-rob_wr combinational path; all ROB writes SHALL come from the FIFO head.

Verification
REQ-032 The bench SHALL cover: slot1 valid, tag=5, val=1, is_br=0, rob_wr_ready=1 -> next cycle rob_wr_valid=1, tag=5, val=0x1, mispred=0 (macro off).
REQ-033 The bench SHALL cover: slots 0,1,2 valid, tags 1,2,3, ready=1 -> ROB writes with tags 1,2,3 on three consecutive cycles.
REQ-034 The bench SHALL cover: branch with tag=4, br_pred_res=0, pc_next=0x60000020 -> rob_wr_mispred=1, rob_wr_pc_next=0x60000020.
REQ-035 The bench SHALL cover: ready=0 while pushing 3 per cycle -> dispatch_stall=1 at count=11, and overflow_err=1 once a 17th result is pushed, with the first 16 tags intact.
REQ-036 The bench SHALL cover: 4 entries queued, flush pulsed with a new valid input -> next cycle rob_wr_valid=0, count=0, and the flush-cycle input is absent.
REQ-037 The bench SHALL cover: macro on, empty FIFO, slot0 tag=7, ready=1 -> rob_wr_valid=1, tag=7 in the same cycle, and the FIFO stays empty.
